// File: rtl/multiplier_fp_pkg.sv
// multiplier_fp_pkg: shared state encoding and datapath select codes for the FP multiplier
package multiplier_fp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXP_ADD,
    SUB_BIAS,
    WAIT_MUL,
    ROUND,
    WRITE,
    RESP
  } state_t;

  localparam logic       SEL_A_EXP   = 1'b0;
  localparam logic       SEL_A_REG   = 1'b1;
  localparam logic [1:0] SEL_B_EXP   = 2'd0;
  localparam logic [1:0] SEL_B_BIAS  = 2'd1;
  localparam logic [1:0] SEL_B_CARRY = 2'd2;
  localparam logic [1:0] SEL_B_ONE   = 2'd3;
  localparam logic [1:0] OP_ADD      = 2'd0;
  localparam logic [1:0] OP_SUB      = 2'd1;

endpackage

// File: rtl/multiplier_fp_ctrl.sv
// multiplier_fp_ctrl: Moore sequencer for the multi-cycle FP multiplier datapath; MULT_FP_WATCHDOG_EN adds a WAIT_MUL watchdog
module multiplier_fp_ctrl
  import multiplier_fp_pkg::*;
`ifdef MULT_FP_WATCHDOG_EN
#(
  parameter int WAIT_LIMIT = 64
)
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  output logic       op_ready,
  output logic       res_valid,
  input  logic       res_ready,
  input  logic       mul_done,
  output logic       start_op,
  output logic       sel_a_operand,
  output logic [1:0] sel_b_operand,
  output logic [1:0] sel_operation,
  output logic       load_exp_result,
  output logic       load_underflow,
  output logic       load_overflow,
  output logic       load_inexact,
  output logic       load_result
`ifdef MULT_FP_WATCHDOG_EN
  ,
  output logic       timeout
`endif
);

  state_t state, state_nx;
  logic   wd_fire;

`ifdef MULT_FP_WATCHDOG_EN
  localparam int CW = $clog2(WAIT_LIMIT + 1);
  logic [CW-1:0] cnt;
  assign wd_fire = state == WAIT_MUL && !mul_done && cnt == CW'(WAIT_LIMIT - 1);
  // cycles spent in WAIT_MUL; zero outside it so every entry starts fresh
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= state == WAIT_MUL ? cnt + CW'(1) : '0;
  // sticky timeout, cleared only by reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) timeout <= 1'b0;
    else if (wd_fire) timeout <= 1'b1;
`else
  assign wd_fire = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  // fixed sequence; only IDLE, WAIT_MUL and RESP wait on inputs
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:     state_nx = op_valid ? EXP_ADD : IDLE;
      EXP_ADD:  state_nx = SUB_BIAS;
      SUB_BIAS: state_nx = WAIT_MUL;
      WAIT_MUL: state_nx = mul_done ? ROUND : wd_fire ? WRITE : WAIT_MUL;
      ROUND:    state_nx = WRITE;
      WRITE:    state_nx = RESP;
      RESP:     state_nx = res_ready ? IDLE : RESP;
      default:  state_nx = IDLE;
    endcase
  end

  // datapath controls decoded from state alone
  always_comb begin
    op_ready        = state == IDLE;
    res_valid       = state == RESP;
    start_op        = state == EXP_ADD;
    sel_a_operand   = state inside {SUB_BIAS, WAIT_MUL, ROUND, WRITE} ? SEL_A_REG : SEL_A_EXP;
    sel_b_operand   = state == SUB_BIAS ? SEL_B_BIAS : state inside {ROUND, WRITE} ? SEL_B_CARRY : SEL_B_EXP;
    sel_operation   = state == SUB_BIAS ? OP_SUB : OP_ADD;
    load_exp_result = state inside {EXP_ADD, SUB_BIAS, ROUND};
    load_underflow  = state == SUB_BIAS;
    load_overflow   = state inside {SUB_BIAS, ROUND};
    load_inexact    = state == WRITE;
    load_result     = state == WRITE;
  end

endmodule

// File: tb/tb_multiplier_fp_ctrl.sv
// tb_multiplier_fp_ctrl: randomized cycle-timeline check of multiplier_fp_ctrl
module tb_multiplier_fp_ctrl;

  localparam int WL = 8;
  localparam logic [12:0] IDLE_V = 13'h1000;
  localparam logic [12:0] RESP_V = 13'h0800;

  logic clk = 1'b0, rst_n = 1'b0, op_valid = 1'b0, res_ready = 1'b0, mul_done = 1'b0;
  logic op_ready, res_valid, start_op, sel_a_operand;
  logic [1:0] sel_b_operand, sel_operation;
  logic load_exp_result, load_underflow, load_overflow, load_inexact, load_result;
  logic timeout;
  logic [12:0] obs;
  int n_cmp = 0, n_bad = 0;
  bit tmo_exp = 1'b0;

  always #5 clk = ~clk;

  assign obs = {op_ready, res_valid, start_op, sel_a_operand, sel_b_operand, sel_operation,
                load_exp_result, load_underflow, load_overflow, load_inexact, load_result};

`ifdef MULT_FP_WATCHDOG_EN
  multiplier_fp_ctrl #(.WAIT_LIMIT(WL)) dut (
`else
  assign timeout = 1'b0;
  multiplier_fp_ctrl dut (
`endif
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .res_valid(res_valid), .res_ready(res_ready), .mul_done(mul_done),
    .start_op(start_op), .sel_a_operand(sel_a_operand), .sel_b_operand(sel_b_operand),
    .sel_operation(sel_operation), .load_exp_result(load_exp_result),
    .load_underflow(load_underflow), .load_overflow(load_overflow),
    .load_inexact(load_inexact), .load_result(load_result)
`ifdef MULT_FP_WATCHDOG_EN
    , .timeout(timeout)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // expected controls in cycle c after accept; r = rounding cycle (-1 if none), w = write cycle
  function automatic logic [12:0] ev(input int c, input int r, input int w);
    logic sa, le, lu, lo, li, st;
    logic [1:0] sb, so;
    st = c == 1;
    sa = c >= 2 && c <= w;
    sb = c == 2 ? 2'd1 : (c == r || c == w) ? 2'd2 : 2'd0;
    so = c == 2 ? 2'd1 : 2'd0;
    le = c == 1 || c == 2 || c == r;
    lu = c == 2;
    lo = c == 2 || c == r;
    li = c == w;
    return {1'b0, 1'b0, st, sa, sb, so, le, lu, lo, li, li};
  endfunction

  // called at a negedge inside an IDLE cycle; returns at a negedge inside an IDLE cycle
  task automatic run_op(input int k, input int stall, input bit wd, input int abort);
    int r, w;
    r = wd ? -1 : k + 2;
    w = wd ? 3 + WL : k + 3;
    chk("accept_ready", op_ready, 1);
    op_valid = 1'b1;
    res_ready = 1'b0;
    for (int c = 1; c <= w; c++) begin
      @(negedge clk);
      op_valid = 1'b0;
      if (wd && c == w) tmo_exp = 1'b1;
      chk($sformatf("ctl c%0d k%0d", c, k), obs, ev(c, r, w));
      chk($sformatf("tmo c%0d", c), timeout, tmo_exp);
      if (c >= 2) mul_done = !wd && c >= 1 + k;
      if (c == abort) begin
        #2 rst_n = 1'b0;
        #1 chk("async_rst", obs, IDLE_V);
        tmo_exp = 1'b0;
        chk("async_rst_tmo", timeout, tmo_exp);
        @(negedge clk);
        chk("in_rst", obs, IDLE_V);
        rst_n = 1'b1;
        return;
      end
    end
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      chk($sformatf("resp s%0d", s), obs, RESP_V);
      chk("resp_tmo", timeout, tmo_exp);
      res_ready = s == stall;
    end
    @(negedge clk);
    res_ready = 1'b0;
    chk("idle_after", obs, IDLE_V);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset", obs, IDLE_V);
    chk("reset_tmo", timeout, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hold", obs, IDLE_V);
    run_op(6, 5, 1'b0, -1);
    run_op(6, 0, 1'b0, 5);
    run_op(2, 0, 1'b0, -1);
    for (int i = 0; i < 12; i++) begin
      int g;
      run_op($urandom_range(2, 8), $urandom_range(0, 3), 1'b0, -1);
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(negedge clk);
        chk("idle_gap", obs, IDLE_V);
      end
    end
`ifdef MULT_FP_WATCHDOG_EN
    run_op(0, 2, 1'b1, -1);
    chk("tmo_sticky", timeout, 1'b1);
    run_op(3, 0, 1'b0, -1);
    chk("tmo_sticky2", timeout, 1'b1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
